// File: rtl/cdm_seq_div16_8_pkg.sv
// Shared definitions for the sequential 16-by-8 restoring divider:
// default widths, FSM state encodings and the divide-by-zero quotient.
package cdm_seq_div16_8_pkg;

    localparam int unsigned NW = 16;
    localparam int unsigned DW = 8;

    // 2'd3 is unused; the FSM treats it as IDLE.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [NW-1:0] QDivZero = 16'hFFFF;

endpackage

// File: rtl/cdm_seq_div16_8_if.sv
// Start/busy/done operand and result bundle for the divider.
interface cdm_seq_div16_8_if
    import cdm_seq_div16_8_pkg::*;
#(
    parameter int unsigned N_W = NW,
    parameter int unsigned D_W = DW
) ();

    logic           start;
    logic [N_W-1:0] N;
    logic [D_W-1:0] D;
    logic           busy;
    logic           done;
    logic [N_W-1:0] Q;
    logic [D_W-1:0] REM;
    logic           ovf;
    logic           dz;

    modport master (
        output start, N, D,
        input  busy, done, Q, REM, ovf, dz
    );

    modport slave (
        input  start, N, D,
        output busy, done, Q, REM, ovf, dz
    );

endinterface

// File: rtl/cdm_seq_div16_8_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, then subtract the divisor if it fits.
module cdm_seq_div16_8_div_step #(
    parameter int unsigned D_W = 8
) (
    input  logic [D_W:0]   p,
    input  logic           din,
    input  logic [D_W-1:0] d,
    output logic [D_W:0]   p_next,
    output logic           qbit
);

    logic [D_W:0] p_sh;

    // The incoming P is always < D, so its MSB is zero and drops out of the shift.
    logic unused_p_msb;
    assign unused_p_msb = p[D_W];

    always_comb begin
        p_sh = {p[D_W-1:0], din};
        if (p_sh >= {1'b0, d}) begin
            p_next = p_sh - {1'b0, d};
            qbit   = 1'b1;
        end else begin
            p_next = p_sh;
            qbit   = 1'b0;
        end
    end

endmodule

// File: rtl/cdm_seq_div16_8.sv
// Sequential restoring divider that recovers a factor and remainder from a
// carry-disregard product; resolves one quotient bit per clock.
module cdm_seq_div16_8
    import cdm_seq_div16_8_pkg::*;
#(
    parameter int unsigned N_W = NW,
    parameter int unsigned D_W = DW
) (
    input logic              clk,
    input logic              rst,
    cdm_seq_div16_8_if.slave bus
);

    localparam int unsigned          CntW   = $clog2(N_W);
    localparam logic [CntW-1:0]      CntMax = CntW'(N_W - 1);

    state_e         state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N_W-1:0] nsh_q, nsh_d;
    logic [D_W:0]   p_q, p_d;
    logic [D_W-1:0] d_q, d_d;
    logic [N_W-1:0] q_q, q_d;
    logic [D_W-1:0] rem_q, rem_d;
    logic           ovf_q, ovf_d;
    logic           dz_q, dz_d;

    logic [D_W:0]   p_step;
    logic           qbit;
    logic [N_W-1:0] nsh_shift;

    cdm_seq_div16_8_div_step #(
        .D_W(D_W)
    ) u_step (
        .p      (p_q),
        .din    (nsh_q[N_W-1]),
        .d      (d_q),
        .p_next (p_step),
        .qbit   (qbit)
    );

    // Quotient bits fill the LSBs vacated by the dividend shift.
    assign nsh_shift = {nsh_q[N_W-2:0], qbit};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nsh_d   = nsh_q;
        p_d     = p_q;
        d_d     = d_q;
        q_d     = q_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    if (bus.D != '0) begin
                        state_d = StBusy;
                        nsh_d   = bus.N;
                        d_d     = bus.D;
                        p_d     = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = StDone;
                        q_d     = N_W'(QDivZero);
                        rem_d   = '0;
                        dz_d    = 1'b1;
                        ovf_d   = 1'b1;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StBusy: begin
                nsh_d = nsh_shift;
                p_d   = p_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntMax) begin
                    state_d = StDone;
                    q_d     = nsh_shift;
                    rem_d   = p_step[D_W-1:0];
                    ovf_d   = |nsh_shift[N_W-1:D_W];
                    dz_d    = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            nsh_q   <= '0;
            p_q     <= '0;
            d_q     <= '0;
            q_q     <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nsh_q   <= nsh_d;
            p_q     <= p_d;
            d_q     <= d_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.busy = (state_q == StBusy);
    assign bus.done = (state_q == StDone);
    assign bus.Q    = q_q;
    assign bus.REM  = rem_q;
    assign bus.ovf  = ovf_q;
    assign bus.dz   = dz_q;

endmodule

// File: tb/tb_cdm_seq_div16_8.sv
// Directed bench for cdm_seq_div16_8: expected results come from a / and %
// model, queued at issue time and popped when done is seen.
module tb_cdm_seq_div16_8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    cdm_seq_div16_8_if bus ();

    cdm_seq_div16_8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [15:0] q;
        logic [7:0]  rem;
        logic        ovf;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    exp_t dropped;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] n, input logic [7:0] d);
        exp_t e;
        if (d == 8'd0) begin
            e = '{q: 16'hFFFF, rem: 8'd0, ovf: 1'b1, dz: 1'b1};
        end else begin
            e.q   = n / {8'd0, d};
            e.rem = 8'(n % {8'd0, d});
            e.ovf = (e.q > 16'd255);
            e.dz  = 1'b0;
        end
        return e;
    endfunction

    task automatic set_ops(input logic [15:0] n, input logic [7:0] d);
        bus.N = n;
        bus.D = d;
        sb.push_back(model(n, d));
    endtask

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic do_op(input logic [15:0] n, input logic [7:0] d, input bit hold);
        bus.start = 1'b1;
        set_ops(n, d);
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        check({tag, "_sb_entry"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_Q"},   32'(bus.Q),   32'(e.q));
            check({tag, "_REM"}, 32'(bus.REM), 32'(e.rem));
            check({tag, "_ovf"}, 32'(bus.ovf), 32'(e.ovf));
            check({tag, "_dz"},  32'(bus.dz),  32'(e.dz));
            last = e;
        end
    endtask

    // k counts negedges after the accepting edge (1 = first cycle after it).
    task automatic wait_done(input string tag, input int k0, input int exp_k,
                             input logic exp_busy);
        int   k = k0;
        logic busy_bad = 1'b0;
        while (bus.done !== 1'b1 && k <= 40) begin
            if (bus.busy !== exp_busy) busy_bad = 1'b1;
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, 32'(k), 32'(exp_k));
        check({tag, "_busy_window"}, 32'(busy_bad), 32'd0);
        check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        check_result(tag);
    endtask

    initial begin
        logic quiet_bad;
        bus.start = 1'b0;
        bus.N     = '0;
        bus.D     = '0;

        @(negedge clk);
        check("rst_outputs", {bus.busy, bus.done, bus.Q, bus.REM, bus.ovf, bus.dz}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", {bus.busy, bus.done, bus.Q, bus.REM, bus.ovf, bus.dz}, 32'd0);

        do_op(16'd15000, 8'd123, 1'b0);
        wait_done("basic", 1, 17, 1'b1);
        repeat (3) @(negedge clk);
        check("hold_idle_Q", 32'(bus.Q), 32'd121);
        check("hold_idle_done", 32'(bus.done), 32'd0);

        do_op(16'd65025, 8'd255, 1'b0);
        wait_done("sq255", 1, 17, 1'b1);
        @(negedge clk);

        do_op(16'd65535, 8'd1, 1'b0);
        wait_done("div1", 1, 17, 1'b1);
        @(negedge clk);
        check("done_one_cycle", 32'(bus.done), 32'd0);

        do_op(16'h1234, 8'd0, 1'b0);
        wait_done("dz", 1, 1, 1'b0);
        @(negedge clk);
        check("dz_after", {30'd0, bus.busy, bus.done}, 32'd0);

        // New start mid-operation must be ignored.
        do_op(16'd40000, 8'd201, 1'b0);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.N     = 16'd100;
        bus.D     = 8'd7;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("ignore", 6, 17, 1'b1);
        @(negedge clk);
        check("ignore_no_requeue", {30'd0, bus.busy, bus.done}, 32'd0);

        // Asynchronous reset mid-operation drops the operation.
        do_op(16'd30000, 8'd250, 1'b0);
        dropped = sb.pop_back();
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async_outputs", {bus.busy, bus.done, bus.Q, bus.REM, bus.ovf, bus.dz}, 32'd0);
        @(negedge clk);
        check("rst_held_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        quiet_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) quiet_bad = 1'b1;
        end
        check("rst_no_done", 32'(quiet_bad), 32'd0);
        do_op(16'd200, 8'd9, 1'b0);
        wait_done("after_rst", 1, 17, 1'b1);
        @(negedge clk);

        // Back-to-back with start held high.
        do_op(16'd1000, 8'd10, 1'b1);
        set_ops(16'd60000, 8'd200);
        wait_done("b2b_0", 1, 17, 1'b1);
        @(negedge clk);
        check("b2b_hold_Q0", 32'(bus.Q), 32'(last.q));
        set_ops(16'd12345, 8'd67);
        wait_done("b2b_1", 1, 17, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_hold_Q1", 32'(bus.Q), 32'(last.q));
        check("b2b_hold_ovf1", 32'(bus.ovf), 32'(last.ovf));
        wait_done("b2b_2", 1, 17, 1'b1);
        @(negedge clk);
        check("final_idle", {30'd0, bus.busy, bus.done}, 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
